// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states and the FIFO entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: registered FIFO, a push is visible at the head on the next cycle.
// Push into a full FIFO and pop from an empty one are ignored; flush empties it in one cycle.
module fetch_fifo #(
    parameter type entry_t = fetch_pkg::fetch_entry_t,
    parameter int  DEPTH   = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: one outstanding imem request, returned words buffered for decode.
// Word reaches decode the cycle after its response; requests stop while the buffer is reserved full.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_next;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_addr_next;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic                  drop;
    logic                  drop_next;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic                  full;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_base;
    entry_t                push_entry;
    entry_t                head;

    assign redirect_aligned = redirect_pc & ~ADDR_WIDTH'(INSTR_BYTES - 1);
    assign pop              = ~empty & instr_ready & ~redirect_valid;
    // Occupancy after this cycle's flush/pop, before any push.
    assign count_base       = redirect_valid ? '0 : count - CNT_W'(pop);
    assign push_entry       = '{pc: fetch_pc, instr: imem_rsp_data};

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_addr_next = req_addr;
        drop_next     = drop;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (count_base < CNT_W'(FIFO_DEPTH)) state_next = REQ;
            end
            REQ: begin
                if (imem_req_ready) state_next = WAIT;
                // Whether or not it is accepted now, this request's response is stale.
                if (redirect_valid) drop_next = 1'b1;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    push      = ~drop & ~redirect_valid & ~full;
                    drop_next = 1'b0;
                    if (count_base + CNT_W'(push) < CNT_W'(FIFO_DEPTH)) state_next = REQ;
                    else                                                  state_next = IDLE;
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (redirect_valid)  fetch_pc_next = redirect_aligned;
        else if (push)       fetch_pc_next = fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        // The request address is captured on entry to REQ and held until accepted.
        if (state_next == REQ && state != REQ) req_addr_next = fetch_pc_next;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
            drop     <= drop_next;
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .arst       (arst),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = req_addr;
    assign instr_valid    = ~empty;
    assign instruction    = head.instr;
    assign instr_pc       = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model answering data=addr, redirect vector table, corner sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_arst;
    logic        w_req_valid, w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_instr_valid, w_instr_ready;
    logic [31:0] w_instruction, w_instr_pc;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_pc;

    instr_fetch_unit dut (
        .clk(clk), .arst(arst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .arst(w_arst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .instruction(w_instruction), .instr_pc(w_instr_pc),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic        pend, w_pend;
    logic [31:0] pend_addr, w_pend_addr;
    int          pend_cnt;
    int          lat;
    logic [31:0] got_pc[$], got_ins[$], req_log[$], w_got_pc[$], w_got_ins[$];

    typedef struct {
        int          mode;      // 0: redirect while WAIT, 1: redirect while REQ stalled
        logic [31:0] target;
        logic [31:0] exp_addr;
    } redir_vec_t;
    redir_vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
        n_cmp++;
        if (idx >= q.size()) begin
            n_fail++;
            $display("FAIL %s: got only %0d entries, expected entry %0d = 0x%08h", name, q.size(), idx, exp);
        end else if (q[idx] !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, q[idx], exp);
        end
    endtask

    // Called mid-cycle: log this cycle's handshakes, then move to the next mid-cycle point.
    task automatic step();
        if (imem_req_valid && imem_req_ready) begin
            pend = 1'b1; pend_addr = imem_req_addr; pend_cnt = lat;
            req_log.push_back(imem_req_addr);
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            got_pc.push_back(instr_pc);
            got_ins.push_back(instruction);
        end
        if (!w_arst && w_req_valid && w_req_ready) begin
            w_pend = 1'b1; w_pend_addr = w_req_addr;
        end
        if (!w_arst && w_instr_valid && w_instr_ready) begin
            w_got_pc.push_back(w_instr_pc);
            w_got_ins.push_back(w_instruction);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = pend_addr; pend = 1'b0;
            end
        end
        w_rsp_valid = w_pend; w_rsp_data = w_pend_addr; w_pend = 1'b0;
    endtask

    task automatic wait_hs(input string name);
        int n = 0;
        while (!(imem_req_valid && imem_req_ready) && n < 100) begin step(); n++; end
        chk(name, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req_valid && n < 100) begin step(); n++; end
        chk(name, 32'(n < 100), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] last, held, old;
        logic        changed;

        vecs[0] = '{mode: 0, target: 32'h0000_0100, exp_addr: 32'h0000_0100};
        vecs[1] = '{mode: 0, target: 32'h0000_07FE, exp_addr: 32'h0000_07FC};
        vecs[2] = '{mode: 1, target: 32'h0000_0203, exp_addr: 32'h0000_0200};
        vecs[3] = '{mode: 1, target: 32'h0000_ABC1, exp_addr: 32'h0000_ABC0};
        vecs[4] = '{mode: 0, target: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};

        arst = 1'b1; w_arst = 1'b1;
        imem_req_ready = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        w_req_ready = 1'b1; w_instr_ready = 1'b1;
        w_redirect_valid = 1'b0; w_redirect_pc = '0;
        w_rsp_valid = 1'b0; w_rsp_data = '0;
        pend = 1'b0; w_pend = 1'b0; pend_cnt = 0; lat = 1;
        pend_addr = '0; w_pend_addr = '0;
        repeat (3) @(negedge clk);

        chk("reset req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset req_addr", imem_req_addr, 32'h0);
        chk("reset instr_valid", 32'(instr_valid), 32'd0);
        chk("reset instruction", instruction, 32'h0);
        chk("reset instr_pc", instr_pc, 32'h0);
        chk("wrap reset req_addr", w_req_addr, 32'hFFFF_FFF8);

        // Zero-wait streaming, both instances.
        arst = 1'b0; w_arst = 1'b0;
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (13) step();
        chk("stream count in 13 cycles", got_pc.size(), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk_q("stream pc", got_pc, i, 32'(i * 4));
            chk_q("stream instruction", got_ins, i, 32'(i * 4));
        end
        chk_q("wrap pc0", w_got_pc, 0, 32'hFFFF_FFF8);
        chk_q("wrap pc1", w_got_pc, 1, 32'hFFFF_FFFC);
        chk_q("wrap pc2", w_got_pc, 2, 32'h0000_0000);
        chk_q("wrap instruction2", w_got_ins, 2, 32'h0000_0000);
        w_arst = 1'b1;

        // Decode stall: buffer fills, head is held, requests stop.
        last = (got_pc.size() > 0) ? got_pc[got_pc.size() - 1] : 32'hDEAD_BEEF;
        instr_ready = 1'b0;
        got_pc.delete(); got_ins.delete();
        held = instr_pc; changed = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (instr_pc !== held) changed = 1'b1;
        end
        chk("stall head held", 32'(changed), 32'd0);
        chk("stall instr_valid", 32'(instr_valid), 32'd1);
        chk("stall req_valid low", 32'(imem_req_valid), 32'd0);
        chk("stall head pc", instr_pc, last + 32'd4);
        instr_ready = 1'b1;
        step(); step();
        chk("release back-to-back pops", got_pc.size(), 32'd2);
        repeat (10) step();
        for (int i = 0; i < 4; i++) chk_q("release pc", got_pc, i, last + 32'(4 * (i + 1)));

        // Redirect vector table.
        lat = 3;
        for (int v = 0; v < 5; v++) begin
            old = 32'hX;
            if (vecs[v].mode == 0) begin
                imem_req_ready = 1'b1;
                wait_hs("redir wait handshake");
                step();
                redirect_valid = 1'b1; redirect_pc = vecs[v].target;
                step();
                chk("redir flush", 32'(instr_valid), 32'd0);
            end else begin
                imem_req_ready = 1'b0;
                wait_req("redir wait req");
                old = imem_req_addr;
                redirect_valid = 1'b1; redirect_pc = vecs[v].target;
                step();
                chk("redir flush", 32'(instr_valid), 32'd0);
                step(); step();
                chk("redir stalled addr held", imem_req_addr, old);
                chk("redir stalled valid held", 32'(imem_req_valid), 32'd1);
                imem_req_ready = 1'b1;
            end
            req_log.delete(); got_pc.delete(); got_ins.delete();
            repeat (20) step();
            if (vecs[v].mode == 1) begin
                chk_q("redir old req completes", req_log, 0, old);
                chk_q("redir new req addr", req_log, 1, vecs[v].exp_addr);
            end else begin
                chk_q("redir new req addr", req_log, 0, vecs[v].exp_addr);
            end
            chk_q("redir first pc", got_pc, 0, vecs[v].exp_addr);
            chk_q("redir first instruction", got_ins, 0, vecs[v].exp_addr);
            chk_q("redir second pc", got_pc, 1, vecs[v].exp_addr + 32'd4);
        end

        // Back-to-back redirects: last one wins.
        wait_hs("b2b handshake");
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
        step();
        req_log.delete(); got_pc.delete(); got_ins.delete();
        repeat (20) step();
        chk_q("b2b req addr", req_log, 0, 32'h0000_0400);
        chk_q("b2b first pc", got_pc, 0, 32'h0000_0400);

        // Redirect in IDLE with a full buffer.
        lat = 1; instr_ready = 1'b0;
        repeat (10) step();
        chk("idle precondition req_valid", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
        step();
        chk("idle redirect req_valid", 32'(imem_req_valid), 32'd1);
        chk("idle redirect req_addr", imem_req_addr, 32'h0000_0500);
        chk("idle redirect flush", 32'(instr_valid), 32'd0);

        // Async reset while WAIT with one buffered entry.
        lat = 3;
        wait_hs("arst first handshake");
        step();
        wait_hs("arst second handshake");
        step();
        chk("arst precondition valid", 32'(instr_valid), 32'd1);
        chk("arst precondition pc", instr_pc, 32'h0000_0500);
        arst = 1'b1; pend = 1'b0; imem_rsp_valid = 1'b0;
        #1;
        chk("arst req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst req_addr", imem_req_addr, 32'h0);
        chk("arst instr_valid", 32'(instr_valid), 32'd0);
        chk("arst instruction", instruction, 32'h0);
        chk("arst instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        step();
        arst = 1'b0; lat = 1; instr_ready = 1'b1;
        req_log.delete(); got_pc.delete(); got_ins.delete();
        repeat (8) step();
        chk_q("post-arst req addr", req_log, 0, 32'h0);
        chk_q("post-arst first pc", got_pc, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
